// File: rtl/proj_seqchk_pkg.sv
// Shared types and defaults for the counter-sequence checker.
package proj_seqchk_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_EW = 8;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    SLIP = 2'd2
  } state_e;

endpackage

// File: rtl/proj_seqchk_if.sv
// vld/rdy stream carrying counter traffic from a source to the checker.
interface proj_seqchk_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/proj_seqchk_rdypat.sv
// Ready throttle: a 4-bit phase counter selects one bit of a fixed pattern.
module proj_seqchk_rdypat #(
  parameter logic [15:0] RDYPAT = 16'hFFFF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic rdy_o
);

  logic [3:0] phase_q;
  logic       rdy_q;

  // Phase advances only while enabled; rdy follows the pattern bit of the current phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 4'd0;
      rdy_q   <= 1'b0;
    end else if (clr_i) begin
      phase_q <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= en_i & RDYPAT[phase_q];
      if (en_i) begin
        phase_q <= phase_q + 4'd1;
      end
    end
  end

  assign rdy_o = rdy_q;

endmodule

// File: rtl/proj_seqchk.sv
// Stream sink that throttles a counter stream, locks onto its sequence and
// counts accepted beats and mismatches.
module proj_seqchk
  import proj_seqchk_pkg::*;
#(
  parameter int          W      = DEF_W,
  parameter int          EW     = DEF_EW,
  parameter int          X      = 1,
  parameter logic [15:0] RDYPAT = 16'hFFFF,
  parameter bit          SYNC   = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  proj_seqchk_if.slave  s_if,
  output logic [EW-1:0] errcntr_o,
  output logic [W-1:0]  beatcntr_o,
  output logic          locked_o,
  output logic          errflag_o
);

  localparam logic [W-1:0]  XW         = W'(X);
  localparam logic [W-1:0]  BEAT_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ERR_ONE    = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ERR_MAX    = {EW{1'b1}};
  localparam state_e        RST_STATE  = SYNC ? HUNT : LOCK;
  localparam logic          RST_LOCKED = SYNC ? 1'b0 : 1'b1;

  logic          rdy_s;
  logic          beat_s;
  logic [W-1:0]  data0_q;
  logic          beat0_q;
  logic [W-1:0]  beatcnt_q;
  state_e        state_q;
  logic [W-1:0]  exp_q;
  logic [EW-1:0] errcnt_q;
  logic          errflag_q;
  logic          locked_q;

  proj_seqchk_rdypat #(.RDYPAT(RDYPAT)) u_rdypat (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .en_i   (en_i),
    .rdy_o  (rdy_s)
  );

  assign s_if.rdy = rdy_s;
  assign beat_s   = s_if.vld & rdy_s;

  // Stage 1: capture accepted beats; a clear drops whatever is arriving.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q   <= {W{1'b0}};
      beat0_q   <= 1'b0;
      beatcnt_q <= {W{1'b0}};
    end else if (clr_i) begin
      data0_q   <= {W{1'b0}};
      beat0_q   <= 1'b0;
      beatcnt_q <= {W{1'b0}};
    end else begin
      beat0_q <= beat_s;
      if (beat_s) begin
        data0_q   <= s_if.data;
        beatcnt_q <= beatcnt_q + BEAT_ONE;
      end
    end
  end

  // Stage 2: sequence FSM with registered lock/error outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RST_STATE;
      exp_q     <= {W{1'b0}};
      errcnt_q  <= {EW{1'b0}};
      errflag_q <= 1'b0;
      locked_q  <= RST_LOCKED;
    end else if (clr_i) begin
      state_q   <= RST_STATE;
      exp_q     <= {W{1'b0}};
      errcnt_q  <= {EW{1'b0}};
      errflag_q <= 1'b0;
      locked_q  <= RST_LOCKED;
    end else begin
      errflag_q <= 1'b0;
      if (beat0_q) begin
        case (state_q)
          HUNT: begin
            exp_q    <= data0_q + XW;
            state_q  <= LOCK;
            locked_q <= 1'b1;
          end
          LOCK, SLIP: begin
            if (data0_q == exp_q) begin
              exp_q    <= exp_q + XW;
              state_q  <= LOCK;
              locked_q <= 1'b1;
            end else begin
              // Resynchronise on the offending value so one glitch costs one error.
              errflag_q <= 1'b1;
              errcnt_q  <= (errcnt_q == ERR_MAX) ? errcnt_q : errcnt_q + ERR_ONE;
              exp_q     <= data0_q + XW;
              state_q   <= SLIP;
              locked_q  <= 1'b0;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign errcntr_o  = errcnt_q;
  assign beatcntr_o = beatcnt_q;
  assign locked_o   = locked_q;
  assign errflag_o  = errflag_q;

endmodule

// File: tb/tb_proj_seqchk.sv
// Directed bench: instance A (W=16, X=1, always ready, hunting) and
// instance B (W=4, X=3, EW=2, alternating ready, starts locked).
module tb_proj_seqchk;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, clr_a, en_b, clr_b;
  logic [7:0]  ec_a;
  logic [15:0] bc_a;
  logic        lk_a, ef_a;
  logic [1:0]  ec_b;
  logic [3:0]  bc_b;
  logic        lk_b, ef_b;

  int errors = 0;
  int checks = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  proj_seqchk_if #(.W(16)) ifa ();
  proj_seqchk_if #(.W(4))  ifb ();

  proj_seqchk #(.W(16), .EW(8), .X(1), .RDYPAT(16'hFFFF), .SYNC(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .clr_i(clr_a), .s_if(ifa),
    .errcntr_o(ec_a), .beatcntr_o(bc_a), .locked_o(lk_a), .errflag_o(ef_a)
  );

  proj_seqchk #(.W(4), .EW(2), .X(3), .RDYPAT(16'hAAAA), .SYNC(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .clr_i(clr_b), .s_if(ifb),
    .errcntr_o(ec_b), .beatcntr_o(bc_b), .locked_o(lk_b), .errflag_o(ef_b)
  );

  always @(negedge clk) begin
    if (ef_b) pulses_b++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Present d and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_a(input logic [15:0] d);
    ifa.data = d;
    ifa.vld  = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (ifa.rdy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("send_a_timeout", 32'd1, 32'd0);
    ifa.vld = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d);
    ifb.data = d;
    ifb.vld  = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (ifb.rdy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("send_b_timeout", 32'd1, 32'd0);
    ifb.vld = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic        ef;
    logic        lk;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[13];
  int   p0;

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{16'(i), 1'b0, 1'b1, 8'd0};
    tbl[10] = '{16'd20, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{16'd21, 1'b0, 1'b1, 8'd1};
    tbl[12] = '{16'd22, 1'b0, 1'b1, 8'd1};

    rst_n = 1'b0;
    en_a = 1'b1; clr_a = 1'b0; en_b = 1'b1; clr_b = 1'b0;
    ifa.data = 16'd0; ifa.vld = 1'b0;
    ifb.data = 4'd0;  ifb.vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_a", ifa.rdy, 1'b0);
    chk("rst_ec_a", ec_a, 8'd0);
    chk("rst_bc_a", bc_a, 16'd0);
    chk("rst_lk_a", lk_a, 1'b0);
    chk("rst_ef_a", ef_a, 1'b0);
    chk("rst_rdy_b", ifb.rdy, 1'b0);
    chk("rst_lk_b", lk_b, 1'b1);
    rst_n = 1'b1;

    // Ready patterns straight out of reset.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rdypat_b", ifb.rdy, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("rdypat_a", ifa.rdy, 1'b1);
    end

    // A: continuous 5..104.
    for (int v = 5; v <= 104; v++) send_a(16'(v));
    ifa.vld = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_bc", bc_a, 16'd100);
    chk("t1_ec", ec_a, 8'd0);
    chk("t1_lk", lk_a, 1'b1);

    // B: continuous stream by 3 through the 4-bit wrap under alternating ready.
    for (int i = 0; i < 18; i++) send_b(4'((3 * i) % 16));
    ifb.vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_ec_b", ec_b, 2'd0);
    chk("t5_bc_b", bc_b, 4'd2);
    chk("t5_lk_b", lk_b, 1'b1);

    // B: five bad beats saturate the 2-bit error counter.
    p0 = pulses_b;
    for (int i = 0; i < 5; i++) send_b(4'd0);
    ifb.vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_ec_b", ec_b, 2'd3);
    chk("t4_pulses_b", pulses_b - p0, 5);
    chk("t4_lk_b", lk_b, 1'b0);

    // A: en=0 drops rdy on the next edge and stalls the stream.
    en_a = 1'b0;
    @(posedge clk);
    #1;
    chk("en0_rdy", ifa.rdy, 1'b0);
    ifa.data = 16'd105; ifa.vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("en0_bc", bc_a, 16'd100);
    chk("en0_rdy_hold", ifa.rdy, 1'b0);
    en_a = 1'b1;
    send_a(16'd105);
    ifa.vld = 1'b0;
    @(posedge clk);
    #1;
    chk("en1_bc", bc_a, 16'd101);
    chk("en1_ec", ec_a, 8'd0);

    // A: clr coinciding with a (bad) beat drops it and restores reset state.
    ifa.data = 16'd200; ifa.vld = 1'b1; clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0; ifa.vld = 1'b0;
    chk("clr_rdy", ifa.rdy, 1'b0);
    chk("clr_bc", bc_a, 16'd0);
    chk("clr_lk", lk_a, 1'b0);
    chk("clr_ec", ec_a, 8'd0);
    @(posedge clk);
    #1;
    chk("clr_drop_ef", ef_a, 1'b0);
    chk("clr_drop_ec", ec_a, 8'd0);

    // A: relock, then a jump triggers one SLIP beat.
    for (int i = 0; i < 13; i++) begin
      send_a(tbl[i].data);
      ifa.vld = 1'b0;
      @(posedge clk);
      #1;
      chk("t3_ef", ef_a, tbl[i].ef);
      chk("t3_lk", lk_a, tbl[i].lk);
      chk("t3_ec", ec_a, tbl[i].ec);
      chk("t3_bc", bc_a, 16'(i + 1));
    end

    // Async reset with a beat sitting in stage 1.
    send_a(16'd23);
    rst_n = 1'b0;
    #1;
    chk("rst2_bc_a", bc_a, 16'd0);
    chk("rst2_ec_a", ec_a, 8'd0);
    chk("rst2_lk_a", lk_a, 1'b0);
    chk("rst2_rdy_a", ifa.rdy, 1'b0);
    chk("rst2_ec_b", ec_b, 2'd0);
    chk("rst2_lk_b", lk_b, 1'b1);
    ifa.vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_lost_ef", ef_a, 1'b0);
    send_a(16'd50);
    ifa.vld = 1'b0;
    @(posedge clk);
    #1;
    chk("relock_lk", lk_a, 1'b1);
    chk("relock_ef", ef_a, 1'b0);
    chk("relock_bc", bc_a, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
